mmc_serial_regs: RTL and testbench

MMC_SERIAL_REGS -- requirements
Module: mmc_serial_regs

---
 rtl/mmc_serial_regs.sv | 127 ++++++++++++
 tb/tb_mmc_serial_regs.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc_serial_regs.sv
// Serial register loader: bits arrive one per CPU write, LSB first, into a
// shifter. The completing write commits the assembled value to the register
// picked by that write's address. A write with din[7] set clears the shifter
// and ORs a control pattern into register 0.
module mmc_serial_regs #(
    parameter int unsigned        SHIFT_W  = 5,
    parameter int unsigned        NUM_REGS = 4,
    parameter int unsigned        SEL_LSB  = 13,
    parameter int unsigned        HOLDOFF  = 1,
    parameter logic [SHIFT_W-1:0] CTRL_OR  = SHIFT_W'(5'b01100)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         ce,
    input  logic                         enable,
    input  logic [15:0]                  prg_ain,
    input  logic                         prg_write,
    input  logic [7:0]                   prg_din,
    output logic [NUM_REGS*SHIFT_W-1:0]  regs_out,
    output logic                         load_strobe,
    output logic [$clog2(NUM_REGS)-1:0]  load_idx,
    output logic [$clog2(SHIFT_W+1)-1:0] bit_count,
    output logic                         busy
);

    localparam int unsigned SEL_W = $clog2(NUM_REGS);
    localparam int unsigned CNT_W = $clog2(SHIFT_W + 1);
    localparam int unsigned HO_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFT_W - 1);
    localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(HOLDOFF);

    logic [SHIFT_W-1:0] regs_q [NUM_REGS];
    logic [SHIFT_W-1:0] regs_d [NUM_REGS];
    logic [SHIFT_W-2:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HO_W-1:0]    ho_q, ho_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               strobe_q, strobe_d;
    logic               busy_q, busy_d;
    logic [SEL_W-1:0]   sel;

    // Only the select field and din[0]/din[7] carry meaning.
    logic unused_c;
    assign unused_c = ^{prg_din[6:1], prg_ain};

    assign sel = prg_ain[SEL_LSB +: SEL_W];

    // Next-state: disable reinitialises; holdoff swallows writes; else shift/load.
    always_comb begin
        regs_d   = regs_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        ho_d     = ho_q;
        idx_d    = idx_q;
        strobe_d = 1'b0;

        if (!enable) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_d[i] = (i == 0) ? CTRL_OR : '0;
            end
            shift_d = '0;
            cnt_d   = '0;
            ho_d    = '0;
            idx_d   = '0;
        end else if (ce) begin
            if (ho_q != '0) begin
                if (!prg_write) begin
                    ho_d = ho_q - HO_W'(1);
                end
            end else if (prg_write && prg_ain[15]) begin
                ho_d = HO_LOAD;
                if (prg_din[7]) begin
                    shift_d   = '0;
                    cnt_d     = '0;
                    regs_d[0] = regs_q[0] | CTRL_OR;
                end else if (cnt_q == LAST_CNT) begin
                    regs_d[sel] = {prg_din[0], shift_q};
                    shift_d     = '0;
                    cnt_d       = '0;
                    idx_d       = sel;
                    strobe_d    = 1'b1;
                end else begin
                    shift_d            = shift_q >> 1;
                    shift_d[SHIFT_W-2] = prg_din[0];
                    cnt_d              = cnt_q + CNT_W'(1);
                end
            end
        end

        busy_d = (cnt_d != '0);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= (i == 0) ? CTRL_OR : '0;
            end
            shift_q  <= '0;
            cnt_q    <= '0;
            ho_q     <= '0;
            idx_q    <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            ho_q     <= ho_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
        end
    end

    // Flatten the register file onto the output bus.
    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_out
        assign regs_out[g*SHIFT_W +: SHIFT_W] = regs_q[g];
    end

    assign load_strobe = strobe_q;
    assign load_idx    = idx_q;
    assign bit_count   = cnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mmc_serial_regs.sv
// Bench for mmc_serial_regs: a default instance plus an 8x8, no-holdoff instance.
module tb_mmc_serial_regs;

    localparam int unsigned SW  = 5;
    localparam int unsigned NR  = 4;
    localparam int unsigned SW8 = 8;
    localparam int unsigned NR8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, ce, enable, en8, prg_write;
    logic [15:0] prg_ain;
    logic [7:0]  prg_din;

    logic [NR*SW-1:0]   regs_out;
    logic               load_strobe, busy;
    logic [1:0]         load_idx;
    logic [2:0]         bit_count;

    logic [NR8*SW8-1:0] regs_out8;
    logic               load_strobe8, busy8;
    logic [2:0]         load_idx8;
    logic [3:0]         bit_count8;

    mmc_serial_regs dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .enable(enable),
        .prg_ain(prg_ain), .prg_write(prg_write), .prg_din(prg_din),
        .regs_out(regs_out), .load_strobe(load_strobe), .load_idx(load_idx),
        .bit_count(bit_count), .busy(busy)
    );

    mmc_serial_regs #(
        .SHIFT_W(8), .NUM_REGS(8), .SEL_LSB(13), .HOLDOFF(0), .CTRL_OR(8'h0C)
    ) dut8 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .enable(en8),
        .prg_ain(prg_ain), .prg_write(prg_write), .prg_din(prg_din),
        .regs_out(regs_out8), .load_strobe(load_strobe8), .load_idx(load_idx8),
        .bit_count(bit_count8), .busy(busy8)
    );

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] val;
    } exp_t;

    exp_t q[$];
    exp_t q8[$];
    int checks = 0, failures = 0;
    int strobes = 0, pushes = 0, strobes8 = 0, pushes8 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] reg5(input int i);
        return regs_out[i*SW +: SW];
    endfunction

    // One clock of stimulus; inputs go quiet just after the edge.
    task automatic cyc(input logic c, input logic w, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        ce = c; prg_write = w; prg_ain = a; prg_din = d;
        @(posedge clk);
        #1;
        ce = 1'b0; prg_write = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic wbit(input logic [15:0] a, input logic b);
        cyc(1'b1, 1'b1, a, {7'h00, b});
        idle();
    endtask

    task automatic push(input logic [2:0] i, input logic [7:0] v);
        exp_t e;
        e.idx = i; e.val = v;
        q.push_back(e);
        pushes++;
    endtask

    // Monitor: every strobe of the default instance must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (load_strobe) begin
            strobes++;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe actual=1 expected=0 idx=%0d", load_idx);
            end else begin
                e = q.pop_front();
                if (load_idx !== e.idx[1:0] || regs_out[int'(e.idx)*SW +: SW] !== e.val[4:0]) begin
                    failures++;
                    $display("FAIL load_event actual idx=%0d val=%0h expected idx=%0d val=%0h",
                             load_idx, regs_out[int'(e.idx)*SW +: SW], e.idx, e.val[4:0]);
                end
            end
        end
    end

    // Monitor for the 8x8 instance.
    always @(negedge clk) begin
        exp_t e;
        if (load_strobe8) begin
            strobes8++;
            checks++;
            if (q8.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe8 actual=1 expected=0 idx=%0d", load_idx8);
            end else begin
                e = q8.pop_front();
                if (load_idx8 !== e.idx || regs_out8[int'(e.idx)*SW8 +: SW8] !== e.val) begin
                    failures++;
                    $display("FAIL load_event8 actual idx=%0d val=%0h expected idx=%0d val=%0h",
                             load_idx8, regs_out8[int'(e.idx)*SW8 +: SW8], e.idx, e.val);
                end
            end
        end
    end

    initial begin
        logic [7:0] pat;
        reset_n = 1'b0; ce = 1'b0; enable = 1'b1; en8 = 1'b0;
        prg_write = 1'b0; prg_ain = 16'h0000; prg_din = 8'h00;

        #12;
        chk("rst_regs", 64'(regs_out), 64'h0000C);
        chk("rst_strobe", 64'(load_strobe), 64'h0);
        chk("rst_idx", 64'(load_idx), 64'h0);
        chk("rst_count", 64'(bit_count), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_regs8", regs_out8, 64'h0C);
        @(negedge clk);
        reset_n = 1'b1;

        // 1,0,1,1,0 to $A000 -> reg1 = 01101
        wbit(16'hA000, 1'b1);
        wbit(16'hA000, 1'b0);
        wbit(16'hA000, 1'b1);
        wbit(16'hA000, 1'b1);
        chk("partial_count", 64'(bit_count), 64'h4);
        chk("partial_busy", 64'(busy), 64'h1);
        push(3'd1, 8'h0D);
        wbit(16'hA000, 1'b0);
        chk("reg1_load", 64'(reg5(1)), 64'h0D);
        chk("reg1_idx", 64'(load_idx), 64'h1);
        chk("reg1_count", 64'(bit_count), 64'h0);
        chk("reg1_busy", 64'(busy), 64'h0);
        chk("reg1_strobes", 64'(strobes), 64'h1);

        // reg0 = 00011, then reset-bit write ORs in 01100
        wbit(16'h8000, 1'b1);
        wbit(16'h8000, 1'b1);
        wbit(16'h8000, 1'b0);
        wbit(16'h8000, 1'b0);
        push(3'd0, 8'h03);
        wbit(16'h8000, 1'b0);
        chk("reg0_load", 64'(reg5(0)), 64'h03);
        wbit(16'h8000, 1'b1);
        chk("reg0_count_mid", 64'(bit_count), 64'h1);
        cyc(1'b1, 1'b1, 16'h8000, 8'h80);
        chk("ctrl_strobe_low", 64'(load_strobe), 64'h0);
        chk("ctrl_reg0", 64'(reg5(0)), 64'h0F);
        chk("ctrl_count", 64'(bit_count), 64'h0);
        idle();
        chk("ctrl_no_strobe", 64'(strobes), 64'h2);

        // enable low reinitialises and beats a simultaneous write
        wbit(16'hA000, 1'b1);
        wbit(16'hA000, 1'b1);
        chk("en_pre_count", 64'(bit_count), 64'h2);
        @(negedge clk);
        enable = 1'b0;
        cyc(1'b1, 1'b1, 16'hA000, 8'h00);
        chk("en_regs", 64'(regs_out), 64'h0000C);
        chk("en_count", 64'(bit_count), 64'h0);
        chk("en_idx", 64'(load_idx), 64'h0);
        chk("en_busy", 64'(busy), 64'h0);
        @(negedge clk);
        enable = 1'b1;

        // holdoff: back-to-back writes count once
        cyc(1'b1, 1'b1, 16'hE000, 8'h01);
        cyc(1'b1, 1'b1, 16'hE000, 8'h01);
        chk("holdoff_count1", 64'(bit_count), 64'h1);
        idle();
        cyc(1'b1, 1'b1, 16'hE000, 8'h01);
        chk("holdoff_count2", 64'(bit_count), 64'h2);
        idle();
        wbit(16'hE000, 1'b0);
        wbit(16'hE000, 1'b1);
        push(3'd3, 8'h0B);
        wbit(16'hE000, 1'b0);
        chk("holdoff_reg3", 64'(reg5(3)), 64'h0B);

        // select comes from the completing write; ignored writes change nothing
        wbit(16'h8000, 1'b1);
        wbit(16'h8000, 1'b0);
        wbit(16'h8000, 1'b0);
        cyc(1'b1, 1'b1, 16'h6000, 8'h01);
        cyc(1'b0, 1'b1, 16'h8000, 8'h01);
        chk("ignored_count", 64'(bit_count), 64'h3);
        wbit(16'hE000, 1'b1);
        push(3'd3, 8'h19);
        wbit(16'hE000, 1'b1);
        chk("sel_reg3", 64'(reg5(3)), 64'h19);
        chk("sel_reg0", 64'(reg5(0)), 64'h0C);
        chk("sel_idx", 64'(load_idx), 64'h3);

        // asynchronous reset mid-sequence
        wbit(16'hA000, 1'b1);
        wbit(16'hA000, 1'b1);
        chk("arst_pre_count", 64'(bit_count), 64'h2);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_regs", 64'(regs_out), 64'h0000C);
        chk("arst_count", 64'(bit_count), 64'h0);
        chk("arst_busy", 64'(busy), 64'h0);
        chk("arst_idx", 64'(load_idx), 64'h0);
        chk("arst_strobe", 64'(load_strobe), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wbit(16'hA000, 1'b0);
        wbit(16'hA000, 1'b1);
        wbit(16'hA000, 1'b1);
        wbit(16'hA000, 1'b1);
        push(3'd1, 8'h1E);
        wbit(16'hA000, 1'b1);
        chk("arst_reg1", 64'(reg5(1)), 64'h1E);

        // 8-bit instance, no holdoff: $A5 to $C000 back to back -> reg6
        @(negedge clk);
        enable = 1'b0;
        en8 = 1'b1;
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                exp_t e;
                e.idx = 3'd6; e.val = 8'hA5;
                q8.push_back(e);
                pushes8++;
            end
            cyc(1'b1, 1'b1, 16'hC000, {7'h00, pat[i]});
            if (i == 3) chk("w8_count4", 64'(bit_count8), 64'h4);
        end
        idle();
        chk("w8_reg6", 64'(regs_out8[6*SW8 +: SW8]), 64'hA5);
        chk("w8_idx", 64'(load_idx8), 64'h6);
        chk("w8_count", 64'(bit_count8), 64'h0);
        chk("w8_reg0", 64'(regs_out8[0 +: SW8]), 64'h0C);

        idle();
        chk("sb_empty", 64'(q.size()), 64'h0);
        chk("sb8_empty", 64'(q8.size()), 64'h0);
        chk("strobe_total", 64'(strobes), 64'(pushes));
        chk("strobe8_total", 64'(strobes8), 64'(pushes8));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
